// File: rtl/core_job_dispatcher.sv
// Job FIFO and round-robin launcher for the worker cores.
// Tracks per-core busy state from end pulses and reports completions.
module core_job_dispatcher #(
  parameter int NCORE = 2,
  parameter int PC_W  = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  input  logic [PC_W-1:0]          job_adr,
  output logic                     job_ready,
  input  logic [NCORE-1:0]         core_end,
  output logic [NCORE-1:0]         start,
  output logic [PC_W-1:0]          start_adr,
  output logic [NCORE-1:0]         core_busy,
  output logic [NCORE-1:0]         done_mask,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     idle_all,
  output logic                     err_spurious
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(NCORE);

  logic [PC_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [RW-1:0]    rr_ptr;
  logic [NCORE-1:0] busy;
  logic [NCORE-1:0] start_q;
  logic [NCORE-1:0] done_q;
  logic [PC_W-1:0]  adr_q;
  logic             err_q;

  logic             push;
  logic             pop;
  logic             found;
  logic [NCORE-1:0] grant;
  logic [RW-1:0]    grant_idx;
  logic [RW-1:0]    rr_next;
  logic [NCORE-1:0] legit_end;
  logic             spur_end;

  assign job_ready    = !rst && (count != CW'(DEPTH));
  assign push         = job_valid && job_ready;
  assign legit_end    = core_end & busy;
  assign spur_end     = |(core_end & ~busy);
  assign start        = start_q;
  assign start_adr    = adr_q;
  assign core_busy    = busy;
  assign done_mask    = done_q;
  assign queue_count  = count;
  assign idle_all     = (count == '0) && (busy == '0);
  assign err_spurious = err_q;

  // Two passes: indices at/after rr_ptr first, then the wrapped ones.
  always_comb begin
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int i = 0; i < NCORE; i++) begin
      if (!found && !busy[i] && i >= int'(rr_ptr)) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = RW'(i);
      end
    end
    for (int i = 0; i < NCORE; i++) begin
      if (!found && !busy[i] && i < int'(rr_ptr)) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = RW'(i);
      end
    end
  end

  assign pop     = (count != '0) && found;
  assign rr_next = (grant_idx == RW'(NCORE - 1)) ? '0 : grant_idx + RW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rr_ptr  <= '0;
      busy    <= '0;
      start_q <= '0;
      done_q  <= '0;
      adr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= job_adr;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rr_ptr  <= rr_next;
        start_q <= grant;
        adr_q   <= mem[rd_ptr];
      end else begin
        start_q <= '0;
        adr_q   <= '0;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      busy   <= (busy & ~legit_end) | (pop ? grant : '0);
      done_q <= legit_end;
      if (spur_end) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_job_dispatcher.sv
// Randomized bench for core_job_dispatcher against a queue-based
// reference model, plus directed reset/queue/full/spurious scenarios.
module tb_core_job_dispatcher;

  localparam int NCORE = 2;
  localparam int PC_W  = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             job_valid;
  logic [PC_W-1:0]  job_adr;
  logic             job_ready;
  logic [NCORE-1:0] core_end;
  logic [NCORE-1:0] start;
  logic [PC_W-1:0]  start_adr;
  logic [NCORE-1:0] core_busy;
  logic [NCORE-1:0] done_mask;
  logic [$clog2(DEPTH):0] queue_count;
  logic             idle_all;
  logic             err_spurious;

  core_job_dispatcher #(
    .NCORE(NCORE), .PC_W(PC_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_adr(job_adr), .job_ready(job_ready),
    .core_end(core_end), .start(start), .start_adr(start_adr),
    .core_busy(core_busy), .done_mask(done_mask),
    .queue_count(queue_count), .idle_all(idle_all),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [PC_W-1:0] mq[$];
  bit [NCORE-1:0]  mbusy;
  int              mrr;
  bit              merr;
  bit [NCORE-1:0]  mstart;
  bit [NCORE-1:0]  mdone;
  logic [PC_W-1:0] madr;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mbusy  = '0;
    mrr    = 0;
    merr   = 0;
    mstart = '0;
    mdone  = '0;
    madr   = '0;
  endtask

  task automatic check_all();
    check("start", 32'(start), 32'(mstart));
    check("start_adr", 32'(start_adr), 32'(madr));
    check("core_busy", 32'(core_busy), 32'(mbusy));
    check("done_mask", 32'(done_mask), 32'(mdone));
    check("queue_count", 32'(queue_count), 32'(mq.size()));
    check("idle_all", 32'(idle_all),
          32'(mq.size() == 0 && mbusy == 0));
    check("err_spurious", 32'(err_spurious), 32'(merr));
  endtask

  // One clock: drive inputs, advance model, compare after the edge.
  task automatic cycle(input bit jv, input logic [PC_W-1:0] adr,
                       input bit [NCORE-1:0] ce);
    bit push;
    int g;
    check("job_ready", 32'(job_ready), 32'(mq.size() != DEPTH));
    job_valid = jv;
    job_adr   = adr;
    core_end  = ce;
    push = jv && (mq.size() != DEPTH);
    g = -1;
    if (mq.size() != 0)
      for (int k = 0; k < NCORE; k++)
        if (g < 0 && !mbusy[(mrr + k) % NCORE]) g = (mrr + k) % NCORE;
    mdone = ce & mbusy;
    if ((ce & ~mbusy) != 0) merr = 1;
    mbusy = mbusy & ~mdone;
    if (g >= 0) begin
      mstart = '0;
      mstart[g] = 1'b1;
      madr = mq.pop_front();
      mbusy[g] = 1'b1;
      mrr = (g + 1) % NCORE;
    end else begin
      mstart = '0;
      madr = '0;
    end
    if (push) mq.push_back(adr);
    @(posedge clk);
    @(negedge clk);
    job_valid = 0;
    core_end  = '0;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1;
    job_valid = 0;
    core_end = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_job_ready", 32'(job_ready), 0);
    check("rst_start", 32'(start), 0);
    check("rst_adr", 32'(start_adr), 0);
    check("rst_busy", 32'(core_busy), 0);
    check("rst_done", 32'(done_mask), 0);
    check("rst_count", 32'(queue_count), 0);
    check("rst_err", 32'(err_spurious), 0);
    rst = 0;
    model_clear();
    #1;
    check("post_rst_ready", 32'(job_ready), 1);
    check("post_rst_idle", 32'(idle_all), 1);
    check("post_rst_count", 32'(queue_count), 0);
  endtask

  initial begin
    rst = 1;
    job_valid = 0;
    job_adr = '0;
    core_end = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    // single job
    cycle(1, 16'h0100, 2'b00);
    check("t2_queued", 32'(queue_count), 1);
    cycle(0, 16'h0000, 2'b00);
    check("t2_start", 32'(start), 32'h1);
    check("t2_adr", 32'(start_adr), 32'h0100);
    check("t2_busy", 32'(core_busy), 32'h1);
    cycle(0, 16'h0000, 2'b00);
    check("t2_start_off", 32'(start), 0);

    // queueing and end pulse
    do_reset();
    cycle(1, 16'h0100, 2'b00);
    cycle(1, 16'h0200, 2'b00);
    check("t3_adr0", 32'(start_adr), 32'h0100);
    cycle(1, 16'h0300, 2'b00);
    check("t3_adr1", 32'(start_adr), 32'h0200);
    check("t3_start1", 32'(start), 32'h2);
    check("t3_count", 32'(queue_count), 1);
    cycle(0, 16'h0000, 2'b10);
    check("t3_done", 32'(done_mask), 32'h2);
    check("t3_busy", 32'(core_busy), 32'h1);
    cycle(0, 16'h0000, 2'b00);
    check("t3_start2", 32'(start), 32'h2);
    check("t3_adr2", 32'(start_adr), 32'h0300);

    // full FIFO with both cores busy
    for (int i = 0; i < DEPTH; i++) cycle(1, 16'(16'h1000 + i), 2'b00);
    check("t4_count", 32'(queue_count), DEPTH);
    check("t4_ready", 32'(job_ready), 0);
    cycle(1, 16'hdead, 2'b00);
    check("t4_no_accept", 32'(queue_count), DEPTH);
    cycle(0, 16'h0000, 2'b01);
    cycle(0, 16'h0000, 2'b00);
    check("t4_count3", 32'(queue_count), DEPTH - 1);
    check("t4_ready1", 32'(job_ready), 1);

    // spurious end
    do_reset();
    cycle(0, 16'h0000, 2'b01);
    check("t5_err", 32'(err_spurious), 1);
    check("t5_done", 32'(done_mask), 0);
    cycle(0, 16'h0000, 2'b00);
    check("t5_err_hold", 32'(err_spurious), 1);

    // randomized traffic, with a mid-run reset
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit [NCORE-1:0] ce;
      ce = '0;
      for (int i = 0; i < NCORE; i++)
        if (mbusy[i]) ce[i] = ($urandom_range(0, 3) == 0);
        else ce[i] = ($urandom_range(0, 99) == 0);
      cycle($urandom_range(0, 9) < 6, 16'($urandom), ce);
      if (n == 300) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
